// File: rtl/mod_addsub_seq.sv
// Limb-serial (A +/- B) mod M over one LIMB-wide slice: pass 1 forms S, pass 2 forms S -/+ M, FIN selects.
// done pulses 9 edges after start is accepted; start is only sampled in IDLE and never queued.
module mod_addsub_seq #(
  parameter int N     = 514,
  parameter int LIMB  = 129,
  parameter int NLIMB = 4
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         start,
  input  logic         subtract,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic [N-1:0] M,
  output logic [N-1:0] result,
  output logic         busy,
  output logic         done
);
  localparam int W   = NLIMB * LIMB;
  localparam int LW  = (NLIMB > 1) ? $clog2(NLIMB) : 1;
  localparam int TOP = N - (NLIMB - 1) * LIMB;  // position of bit N inside the top limb
  localparam logic [LW-1:0] LAST = LW'(NLIMB - 1);

  typedef enum logic [1:0] {IDLE, P1, P2, FIN} state_t;

  state_t        r_state;
  state_t        w_state_nxt;

  logic [W-1:0]  r_a;
  logic [W-1:0]  r_b;
  logic [W-1:0]  r_s;
  logic [W-1:0]  r_t;
  logic [N-1:0]  r_m;
  logic          r_sub;
  logic          r_carry;
  logic          r_c1;
  logic          r_nb;
  logic [LW-1:0] r_limb;
  logic [N-1:0]  r_result;
  logic          r_busy;
  logic          r_done;

  logic          w_accept;
  logic          w_last;
  logic [W-1:0]  w_s_ext;
  logic [W-1:0]  w_mx;
  logic [LIMB-1:0] w_x;
  logic [LIMB-1:0] w_y;
  logic [LIMB:0] w_sum;
  logic [N-1:0]  w_res;
  logic          w_unused_bits;

  assign w_last = (r_limb == LAST);

  // Second-pass operands: add mode computes S - M over N+1 bits, subtract mode S + M mod 2^N.
  always_comb begin
    w_s_ext = {{(W-N){1'b0}}, r_s[N-1:0]};
    w_mx    = {{(W-N){1'b0}}, r_m};
    if (!r_sub) begin
      w_s_ext[N] = r_c1;
      w_mx       = {{(W-N){1'b0}}, ~r_m};
      w_mx[N]    = 1'b1;
    end
  end

  assign w_x   = (r_state == P2) ? w_s_ext[r_limb*LIMB +: LIMB] : r_a[r_limb*LIMB +: LIMB];
  assign w_y   = r_b[r_limb*LIMB +: LIMB];
  assign w_sum = {1'b0, w_x} + {1'b0, w_y} + {{LIMB{1'b0}}, r_carry};

  always_comb begin
    w_res = r_s[N-1:0];
    if (r_sub) begin
      if (!r_c1) w_res = r_t[N-1:0];
    end else begin
      if (r_nb) w_res = r_t[N-1:0];
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (start) begin
          w_accept    = 1'b1;
          w_state_nxt = P1;
        end
      end
      P1:      if (w_last) w_state_nxt = P2;
      P2:      if (w_last) w_state_nxt = FIN;
      FIN:     w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_a      <= '0;
      r_b      <= '0;
      r_s      <= '0;
      r_t      <= '0;
      r_m      <= '0;
      r_sub    <= 1'b0;
      r_carry  <= 1'b0;
      r_c1     <= 1'b0;
      r_nb     <= 1'b0;
      r_limb   <= '0;
      r_result <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        IDLE: begin
          r_busy <= w_accept;
          if (w_accept) begin
            r_a     <= {{(W-N){1'b0}}, A};
            r_b     <= subtract ? ~{{(W-N){1'b0}}, B} : {{(W-N){1'b0}}, B};
            r_m     <= M;
            r_sub   <= subtract;
            r_carry <= subtract;
            r_limb  <= '0;
          end
        end
        P1: begin
          r_s[r_limb*LIMB +: LIMB] <= w_sum[LIMB-1:0];
          if (w_last) begin
            // Inverted padding flips bit N in subtract mode, so undo it to recover the bit-N carry.
            r_c1    <= w_sum[TOP] ^ r_sub;
            r_carry <= ~r_sub;
            r_b     <= w_mx;
            r_limb  <= '0;
          end else begin
            r_carry <= w_sum[LIMB];
            r_limb  <= r_limb + LW'(1);
          end
        end
        P2: begin
          r_t[r_limb*LIMB +: LIMB] <= w_sum[LIMB-1:0];
          r_carry <= w_sum[LIMB];
          if (w_last) begin
            r_nb   <= w_sum[TOP+1];
            r_limb <= '0;
          end else begin
            r_limb <= r_limb + LW'(1);
          end
        end
        FIN: begin
          r_result <= w_res;
          r_done   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign w_unused_bits = ^{r_s[W-1:N], r_t[W-1:N]};

  assign result = r_result;
  assign busy   = r_busy;
  assign done   = r_done;

endmodule

// File: tb/tb_mod_addsub_seq.sv
// Bench for mod_addsub_seq: vector table plus handshake/reset sequences, results checked via a scoreboard queue.
module tb_mod_addsub_seq;
  localparam int N = 514;

  logic         clk;
  logic         rstn;
  logic         start;
  logic         subtract;
  logic [N-1:0] A;
  logic [N-1:0] B;
  logic [N-1:0] M;
  logic [N-1:0] result;
  logic         busy;
  logic         done;

  mod_addsub_seq dut (
    .clk      (clk),
    .rstn     (rstn),
    .start    (start),
    .subtract (subtract),
    .A        (A),
    .B        (B),
    .M        (M),
    .result   (result),
    .busy     (busy),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string        nm;
    bit           sub;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [N-1:0] m;
    logic [N-1:0] exp;
  } vec_t;

  vec_t         vt[$];
  logic [N-1:0] q_exp[$];
  int           done_cyc[$];
  int           chk_cnt;
  int           pass_cnt;
  int           cyc;
  string        cur_nm;

  task automatic check_v(input string nm, input logic [N-1:0] act, input logic [N-1:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  task automatic check_i(input string nm, input int act, input int exp);
    chk_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d want %0d", nm, act, exp);
  endtask

  // One clock; sample on the falling edge and retire a scoreboard entry on every done.
  task automatic tick();
    logic [N-1:0] e;
    @(negedge clk);
    cyc++;
    if (done === 1'b1) begin
      done_cyc.push_back(cyc);
      if (q_exp.size() == 0) begin
        chk_cnt++;
        $display("FAIL spurious_done: done=1 at cycle %0d with no request pending, want done=0", cyc);
      end else begin
        e = q_exp.pop_front();
        check_v({cur_nm, "_result"}, result, e);
      end
    end
  endtask

  function automatic logic [N-1:0] model(input bit sub, input logic [N-1:0] a, input logic [N-1:0] b,
                                         input logic [N-1:0] m);
    logic [N+1:0] t;
    if (!sub) begin
      t = a + b;
      if (t >= m) t = t - m;
    end else if (a >= b) begin
      t = a - b;
    end else begin
      t = a + m - b;
    end
    return t[N-1:0];
  endfunction

  function automatic logic [N-1:0] rnd_wide();
    logic [N-1:0] r;
    r = '0;
    for (int i = 0; i < N; i += 32) r = (r << 32) | N'($urandom);
    return r;
  endfunction

  task automatic add_vec(input string nm, input bit sub, input logic [N-1:0] a, input logic [N-1:0] b,
                         input logic [N-1:0] m, input logic [N-1:0] exp);
    vec_t v;
    v.nm = nm; v.sub = sub; v.a = a; v.b = b; v.m = m; v.exp = exp;
    vt.push_back(v);
  endtask

  // Single operation with latency/busy checks; inputs are scrambled right after acceptance.
  task automatic run_op(input string nm, input bit sub, input logic [N-1:0] a, input logic [N-1:0] b,
                        input logic [N-1:0] m, input logic [N-1:0] exp);
    int c0;
    int n0;
    cur_nm = nm;
    q_exp.push_back(exp);
    subtract = sub; A = a; B = b; M = m; start = 1'b1;
    c0 = cyc;
    n0 = done_cyc.size();
    tick();
    start = 1'b0;
    subtract = ~sub; A = ~a; B = ~b; M = ~m;
    check_i({nm, "_busy_after_accept"}, int'(busy), 1);
    for (int i = 0; i < 20 && done_cyc.size() == n0; i++) tick();
    if (done_cyc.size() == n0) begin
      chk_cnt++;
      $display("FAIL %s_timeout: no done within 20 cycles, want done at cycle +10", nm);
      void'(q_exp.pop_front());
    end else begin
      check_i({nm, "_latency"}, done_cyc[n0] - c0, 10);
    end
    tick();
    check_i({nm, "_done_single"}, int'(done), 0);
    check_i({nm, "_busy_cleared"}, int'(busy), 0);
  endtask

  initial begin
    logic [N-1:0] one;
    logic [N-1:0] mbig;
    logic [N-1:0] m5;
    logic [N-1:0] ra, rb, rm;
    int c0;
    int n0;

    chk_cnt = 0; pass_cnt = 0; cyc = 0; cur_nm = "init";
    rstn = 1'b0; start = 1'b0; subtract = 1'b0; A = '0; B = '0; M = '0;
    repeat (3) tick();
    rstn = 1'b1;
    tick();
    check_v("reset_result", result, '0);
    check_i("reset_done", int'(done), 0);
    check_i("reset_busy", int'(busy), 0);

    one  = 1;
    mbig = '1;
    mbig = mbig - 2;                 // 2^514 - 3
    m5   = (one << 513) + one;       // 2^513 + 1
    add_vec("add_nowrap", 0, 5, 6, 13, 11);
    add_vec("add_wrap_big", 0, mbig - 1, mbig - 1, mbig, mbig - 2);
    add_vec("sub_borrow", 1, 4, 9, 13, 8);
    add_vec("sub_noborrow", 1, 9, 4, 13, 5);
    add_vec("sub_equal", 1, 7, 7, 13, 0);
    add_vec("add_limb_carry", 0, (one << 129) - one, 1, m5, one << 129);
    add_vec("sub_limb_borrow", 1, one << 129, 1, m5, (one << 129) - one);
    add_vec("add_exact_m", 0, mbig - 1, 1, mbig, 0);
    add_vec("sub_zero_minus_one", 1, 0, 1, mbig, mbig - 1);
    foreach (vt[i]) run_op(vt[i].nm, vt[i].sub, vt[i].a, vt[i].b, vt[i].m, vt[i].exp);

    // start re-pulsed during P1 must be ignored
    cur_nm = "p1_repulse";
    q_exp.push_back(11);
    n0 = done_cyc.size();
    subtract = 0; A = 5; B = 6; M = 13; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (20) tick();
    check_i("p1_repulse_done_count", done_cyc.size() - n0, 1);

    // start held high: back-to-back operations every 10 cycles
    cur_nm = "held_start";
    repeat (3) q_exp.push_back(11);
    n0 = done_cyc.size();
    c0 = cyc;
    start = 1'b1;
    repeat (30) tick();
    start = 1'b0;
    repeat (15) tick();
    check_i("held_done_count", done_cyc.size() - n0, 3);
    if (done_cyc.size() - n0 >= 3) begin
      check_i("held_done1_cycle", done_cyc[n0] - c0, 10);
      check_i("held_done2_cycle", done_cyc[n0+1] - c0, 20);
      check_i("held_done3_cycle", done_cyc[n0+2] - c0, 30);
    end

    // reset asserted during P2 aborts without a done
    cur_nm = "reset_mid_p2";
    n0 = done_cyc.size();
    subtract = 0; A = 5; B = 6; M = 13; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    rstn = 1'b0;
    #1;
    check_v("midreset_result", result, '0);
    check_i("midreset_busy", int'(busy), 0);
    check_i("midreset_done", int'(done), 0);
    repeat (2) tick();
    rstn = 1'b1;
    repeat (15) tick();
    check_i("midreset_no_done", done_cyc.size() - n0, 0);

    for (int k = 0; k < 4; k++) begin
      rm = rnd_wide() | N'(1);
      ra = rnd_wide() % rm;
      rb = rnd_wide() % rm;
      run_op($sformatf("rand%0d", k), k[0], ra, rb, rm, model(k[0], ra, rb, rm));
    end

    check_i("scoreboard_drained", q_exp.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
